// File: rtl/judge_pkg.sv
// judge_pkg: shared types, lane indices and saturating arithmetic for note_judge.
package judge_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, DONE} judge_state_t;
    localparam int LANES = 3;
    localparam int LANE_ONE = 0;
    localparam int LANE_TWO = 1;
    localparam int LANE_SPACE = 2;
    localparam int COMBO_BONUS_TH = 10;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[31:0];
    endfunction
endpackage

// File: rtl/note_judge_key_edge.sv
// key_edge: registered rising-edge detector; press is high in the cycle a key first rises.
module key_edge #(
    parameter int W = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] key,
    output logic [W-1:0] press
);
    logic [W-1:0] key_q;

    always_ff @(posedge Clk or posedge Reset)
        if (Reset) key_q <= '0;
        else       key_q <= key;

    assign press = key & ~key_q;
endmodule

// File: rtl/note_judge.sv
// note_judge: 3-lane note highway with strike-row judging, score/combo/miss counters.
// Optional JUDGE_GHOST_PENALTY_EN: a press on an empty strike-row lane resets combo.
module note_judge
    import judge_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int SCORE_W = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start_,
    input  logic                 end_,
    input  logic                 shift,
    input  logic                 one,
    input  logic                 two,
    input  logic                 space,
    input  logic [2:0]           note_in,
    output logic [3*DEPTH-1:0]   lane_map,
    output logic [SCORE_W-1:0]   score,
    output logic [7:0]           combo,
    output logic [7:0]           miss_cnt,
    output logic [2:0]           hit,
    output logic [2:0]           miss,
    output logic                 playing
);
    localparam int MW = 3 * DEPTH;

    judge_state_t state, state_n;
    logic [LANES-1:0] keys, press;
    logic [2:0] row0, hits, misses;
    logic [1:0] n_hit, n_miss;
    logic [2:0] gain;
    logic       active, kill;

    assign keys[LANE_ONE]   = one;
    assign keys[LANE_TWO]   = two;
    assign keys[LANE_SPACE] = space;

    key_edge #(.W(LANES)) u_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .key   (keys),
        .press (press)
    );

    always_ff @(posedge Clk or posedge Reset)
        if (Reset) state <= IDLE;
        else       state <= state_n;

    always_comb
        state_n = start_ ? PLAY : (state == PLAY && end_) ? DONE : state;

    always_comb begin
        playing = state == PLAY;
        active  = playing && !start_;
    end

    // Judge against the pre-shift strike row; hit notes are removed before miss detection.
    assign row0   = lane_map[2:0];
    assign hits   = press & row0;
    assign misses = shift ? row0 & ~hits : 3'b000;
    assign n_hit  = 2'($countones(hits));
    assign n_miss = 2'($countones(misses));
    assign gain   = (combo >= 8'(COMBO_BONUS_TH)) ? {n_hit, 1'b0} : {1'b0, n_hit};

`ifdef JUDGE_GHOST_PENALTY_EN
    assign kill = |misses || |(press & ~row0);
`else
    assign kill = |misses;
`endif

    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            lane_map <= '0;
            score    <= '0;
            combo    <= '0;
            miss_cnt <= '0;
            hit      <= '0;
            miss     <= '0;
        end else begin
            hit  <= active ? hits : 3'b000;
            miss <= active ? misses : 3'b000;
            if (start_) begin
                lane_map <= '0;
                score    <= '0;
                combo    <= '0;
                miss_cnt <= '0;
            end else if (active) begin
                lane_map <= shift ? {note_in, lane_map[MW-1:3]} : {lane_map[MW-1:3], row0 & ~hits};
                score    <= SCORE_W'(sat_add(32'(score), 32'(gain), 32'({SCORE_W{1'b1}})));
                combo    <= kill ? 8'd0 : 8'(sat_add(32'(combo), 32'(n_hit), 32'd255));
                miss_cnt <= 8'(sat_add(32'(miss_cnt), 32'(n_miss), 32'd255));
            end
        end
endmodule

// File: tb/tb_note_judge.sv
// tb_note_judge: directed + randomized stimulus against a row-array reference model.
module tb_note_judge;
    localparam int DEPTH = 8;
    localparam int SCORE_W = 16;
`ifdef JUDGE_GHOST_PENALTY_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    logic Clk = 0, Reset = 0, start_ = 0, end_ = 0, shift = 0, one = 0, two = 0, space = 0;
    logic [2:0] note_in = 0;
    logic [3*DEPTH-1:0] lane_map;
    logic [SCORE_W-1:0] score;
    logic [7:0] combo, miss_cnt;
    logic [2:0] hit, miss;
    logic playing;

    note_judge #(.DEPTH(DEPTH), .SCORE_W(SCORE_W)) dut (
        .Clk(Clk), .Reset(Reset), .start_(start_), .end_(end_), .shift(shift),
        .one(one), .two(two), .space(space), .note_in(note_in),
        .lane_map(lane_map), .score(score), .combo(combo), .miss_cnt(miss_cnt),
        .hit(hit), .miss(miss), .playing(playing)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0, n_err = 0;
    bit in_song;
    logic [2:0] m_rows[DEPTH];
    int m_score, m_combo, m_miss;
    logic [2:0] m_hit, m_missv, m_keyq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < DEPTH; r++) m_rows[r] = 3'b000;
        m_score = 0; m_combo = 0; m_miss = 0; m_hit = 0; m_missv = 0;
    endtask

    task automatic check_all();
        logic [3*DEPTH-1:0] img;
        for (int r = 0; r < DEPTH; r++) img[3*r +: 3] = m_rows[r];
        chk("lane_map", 32'(lane_map), 32'(img));
        chk("score", 32'(score), 32'(m_score));
        chk("combo", 32'(combo), 32'(m_combo));
        chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
        chk("hit", 32'(hit), 32'(m_hit));
        chk("miss", 32'(miss), 32'(m_missv));
        chk("playing", 32'(playing), 32'(in_song));
    endtask

    task automatic model_step(input logic s, e, sh, input logic [2:0] k, nin);
        logic [2:0] press;
        int nh, nm;
        bit ghost;
        press = k & ~m_keyq;
        m_keyq = k;
        m_hit = 0; m_missv = 0;
        if (s) begin
            in_song = 1;
            model_clear();
        end else if (in_song) begin
            nh = 0; ghost = 0;
            for (int l = 0; l < 3; l++)
                if (press[l]) begin
                    if (m_rows[0][l]) begin
                        m_rows[0][l] = 1'b0; m_hit[l] = 1'b1; nh++;
                    end else ghost = 1;
                end
            m_score = m_score + nh * (m_combo >= 10 ? 2 : 1);
            if (m_score > 65535) m_score = 65535;
            m_combo = m_combo + nh > 255 ? 255 : m_combo + nh;
            if (sh) begin
                m_missv = m_rows[0];
                nm = int'(m_missv[0]) + int'(m_missv[1]) + int'(m_missv[2]);
                m_miss = m_miss + nm > 255 ? 255 : m_miss + nm;
                if (nm > 0) m_combo = 0;
                for (int r = 0; r < DEPTH - 1; r++) m_rows[r] = m_rows[r+1];
                m_rows[DEPTH-1] = nin;
            end
            if (GHOST && ghost) m_combo = 0;
            if (e) in_song = 0;
        end
    endtask

    task automatic cyc(input logic s, e, sh, input logic [2:0] k, nin);
        start_ = s; end_ = e; shift = sh;
        one = k[0]; two = k[1]; space = k[2];
        note_in = nin;
        @(posedge Clk);
        model_step(s, e, sh, k, nin);
        #1 check_all();
    endtask

    task automatic do_reset();
        Reset = 1;
        #2;
        in_song = 0; m_keyq = 0;
        model_clear();
        check_all();
        Reset = 0;
    endtask

    initial begin
        logic [2:0] k;
        in_song = 0; m_keyq = 0;
        model_clear();
        do_reset();
        // walk one lane-0 note down the highway until it falls off as a miss
        cyc(1, 0, 0, 3'b000, 3'b000);
        cyc(0, 0, 1, 3'b000, 3'b001);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 3'b000, 3'b000);
        // lane-1 hit, then hold the key
        cyc(0, 0, 1, 3'b000, 3'b010);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 3'b000, 3'b000);
        cyc(0, 0, 0, 3'b010, 3'b000);
        cyc(0, 0, 0, 3'b010, 3'b000);
        cyc(0, 0, 0, 3'b000, 3'b000);
        do_reset();
        // full chords with simultaneous shift to push combo past the bonus threshold
        cyc(1, 0, 0, 3'b000, 3'b000);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 3'b000, 3'b111);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1, 3'b111, 3'b111);
            cyc(0, 0, 0, 3'b000, 3'b000);
        end
        cyc(0, 0, 0, 3'b111, 3'b000);
        cyc(0, 0, 0, 3'b000, 3'b000);
        cyc(0, 0, 0, 3'b100, 3'b000);
        cyc(0, 0, 0, 3'b000, 3'b000);
        // freeze after end, then restart with start_ and end_ together
        cyc(0, 1, 0, 3'b000, 3'b000);
        cyc(0, 0, 1, 3'b111, 3'b101);
        cyc(0, 0, 1, 3'b000, 3'b011);
        cyc(1, 1, 1, 3'b000, 3'b111);
        cyc(0, 0, 1, 3'b000, 3'b111);
        k = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 799) == 0) do_reset();
            for (int l = 0; l < 3; l++) if ($urandom_range(0, 2) == 0) k[l] = ~k[l];
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 299) == 0,
                $urandom_range(0, 2) == 0, k, 3'($urandom_range(0, 7)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
